// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - one-hot load-type codes driven on rmem (bit0..4 = LB,LH,LW,LBU,LHU)
//   - FSM state enum
//   - helper mapping a load funct3 to its rmem one-hot code
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [4:0] RMEM_LB  = 5'b00001;
  localparam logic [4:0] RMEM_LH  = 5'b00010;
  localparam logic [4:0] RMEM_LW  = 5'b00100;
  localparam logic [4:0] RMEM_LBU = 5'b01000;
  localparam logic [4:0] RMEM_LHU = 5'b10000;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } lsu_state_t;

  // Undefined load codes map to zero so they can never strobe memory.
  function automatic logic [4:0] rmem_onehot(input logic [2:0] funct3);
    logic [4:0] code;
    code = '0;
    case (funct3)
      F3_B:    code = RMEM_LB;
      F3_H:    code = RMEM_LH;
      F3_W:    code = RMEM_LW;
      F3_BU:   code = RMEM_LBU;
      F3_HU:   code = RMEM_LHU;
      default: code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational load-data extraction and extension.
// Ports:
//   funct3    in  3   registered load width/sign code
//   offset    in  2   registered byte offset within the word
//   load_data in  32  raw word returned by data memory
//   result    out 32  selected byte/halfword/word, sign- or zero-extended
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] load_data,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = load_data[7:0];
    case (offset)
      2'd0:    byte_sel = load_data[7:0];
      2'd1:    byte_sel = load_data[15:8];
      2'd2:    byte_sel = load_data[23:16];
      default: byte_sel = load_data[31:24];
    endcase
    half_sel = offset[1] ? load_data[31:16] : load_data[15:0];
  end

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_W:    result = load_data;
      F3_BU:   result = {24'd0, byte_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit with a single-cycle memory read latency.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    upstream handshake
//   req_load/req_store     request type; req_funct3 width/sign code
//   req_addr/req_wdata     byte address and store data; req_rd load target
//   wmem                   byte write enables to data memory
//   rmem                   one-hot load type (LB,LH,LW,LBU,LHU)
//   mem_addr               word index into data memory
//   store_data             lane-replicated store data
//   load_data              memory read data, valid the cycle after rmem
//   wb_valid/wb_rd/wb_data load writeback, one-cycle pulse
//   misalign/bad_addr      fault pulse for misaligned or malformed requests
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic [31:0] bad_addr
);

  lsu_state_t  state;
  lsu_state_t  state_next;

  logic        accept;
  logic        fault;
  logic        do_load;
  logic        do_store;
  logic        addr_misaligned;
  logic        load_f3_ok;
  logic        store_f3_ok;

  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [4:0]  ld_rd;
  logic [31:0] ext_result;

  // Ready is also forced low while reset is held so nothing is accepted.
  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_addr  = {2'b00, req_addr[31:2]};

  // Request classification
  always_comb begin
    load_f3_ok  = 1'b0;
    store_f3_ok = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: begin
        load_f3_ok  = 1'b1;
        store_f3_ok = 1'b1;
      end
      F3_BU, F3_HU: load_f3_ok = 1'b1;
      default: begin
        load_f3_ok  = 1'b0;
        store_f3_ok = 1'b0;
      end
    endcase

    // funct3[1:0] encodes the width for both loads and stores.
    addr_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    // Malformed requests (both types, undefined width) share the fault path.
    fault = (req_load || req_store) &&
            ((req_load && req_store) ||
             (req_load && !load_f3_ok) ||
             (req_store && !store_f3_ok) ||
             addr_misaligned);

    do_load  = accept && req_load && !fault;
    do_store = accept && req_store && !fault;
  end

  // Memory-side strobes and store lane replication
  always_comb begin
    wmem       = '0;
    rmem       = '0;
    store_data = req_wdata;

    case (req_funct3)
      F3_B:    store_data = {4{req_wdata[7:0]}};
      F3_H:    store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase

    if (do_store) begin
      case (req_funct3)
        F3_B:    wmem = 4'b0001 << req_addr[1:0];
        F3_H:    wmem = req_addr[1] ? 4'b1100 : 4'b0011;
        default: wmem = '1;
      endcase
    end

    if (do_load) begin
      rmem = rmem_onehot(req_funct3);
    end
  end

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (do_load) state_next = LOAD_WAIT;
      LOAD_WAIT: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  lsu_load_ext u_load_ext (
    .funct3    (ld_funct3),
    .offset    (ld_offset),
    .load_data (load_data),
    .result    (ext_result)
  );

  // Load context, writeback and fault reporting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_funct3 <= '0;
      ld_offset <= '0;
      ld_rd     <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      bad_addr  <= '0;
    end else begin
      if (do_load) begin
        ld_funct3 <= req_funct3;
        ld_offset <= req_addr[1:0];
        ld_rd     <= req_rd;
      end

      wb_valid <= (state == LOAD_WAIT);
      if (state == LOAD_WAIT) begin
        wb_rd   <= ld_rd;
        wb_data <= ext_result;
      end

      misalign <= accept && fault;
      if (accept && fault) begin
        bad_addr <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic [31:0] bad_addr;

  int compared;
  int mismatched;

  // DUT-side word memory (the environment) and byte-level reference model
  logic [31:0] mem [0:63];
  logic [7:0]  ref_bytes [0:259];
  logic [31:0] last_wb;

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .wmem       (wmem),
    .rmem       (rmem),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .load_data  (load_data),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .misalign   (misalign),
    .bad_addr   (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wmem[i]) mem[mem_addr[5:0]][8*i +: 8] <= store_data[8*i +: 8];
    end
    if (rmem != 5'd0) load_data <= mem[mem_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int unsigned a, input int unsigned n, input bit sgn);
    logic [31:0] v;
    v = 32'd0;
    for (int unsigned i = 0; i < n; i++) v = v | ({24'd0, ref_bytes[a + i]} << (8 * i));
    if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic void model_store(input int unsigned a, input int unsigned n, input logic [31:0] d);
    for (int unsigned i = 0; i < n; i++) ref_bytes[a + i] = d[8*i +: 8];
  endfunction

  task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    int unsigned n;
    bit sgn, ok_ld, ok_st, mis, flt, e_ld, e_st;
    logic [3:0]  e_wmem;
    logic [4:0]  e_rmem;
    logic [31:0] e_sd, e_val;
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    sgn   = !f3[2];
    ok_ld = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    ok_st = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    mis   = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0);
    flt   = (ld || st) && ((ld && st) || (ld && !ok_ld) || (st && !ok_st) || mis);
    e_ld  = ld && !flt;
    e_st  = st && !flt;
    e_wmem = e_st ? 4'(((1 << n) - 1) << a[1:0]) : 4'd0;
    e_rmem = 5'd0;
    if (e_ld) e_rmem = 5'd1 << ((f3 == 3'd0) ? 0 : (f3 == 3'd1) ? 1 : (f3 == 3'd2) ? 2 : (f3 == 3'd4) ? 3 : 4);
    e_sd  = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
    e_val = model_load(a, n, sgn);

    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = d; req_rd = rd;
    #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    chk("wmem", {28'd0, wmem}, {28'd0, e_wmem});
    chk("rmem", {27'd0, rmem}, {27'd0, e_rmem});
    chk("mem_addr", mem_addr, a >> 2);
    if (e_st) chk("store_data", store_data, e_sd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("misalign", {31'd0, misalign}, {31'd0, flt});
    if (flt) chk("bad_addr", bad_addr, a);
    if (e_ld) begin
      chk("req_ready_wait", {31'd0, req_ready}, 32'd0);
      chk("wb_early", {31'd0, wb_valid}, 32'd0);
      @(posedge clk); #1;
      chk("wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      chk("wb_data", wb_data, e_val);
      last_wb = wb_data;
    end
    @(posedge clk); #1;
    chk("wb_after", {31'd0, wb_valid}, 32'd0);
    chk("misalign_after", {31'd0, misalign}, 32'd0);
    if (e_st) model_store(a, n, d);
  endtask

  initial begin
    compared = 0; mismatched = 0; last_wb = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 260; i++) ref_bytes[i] = '0;
    mem[16] = 32'h80817F01;
    ref_bytes[8'h40] = 8'h01; ref_bytes[8'h41] = 8'h7F;
    ref_bytes[8'h42] = 8'h81; ref_bytes[8'h43] = 8'h80;
    mem[17] = 32'h12345678;
    ref_bytes[8'h44] = 8'h78; ref_bytes[8'h45] = 8'h56;
    ref_bytes[8'h46] = 8'h34; ref_bytes[8'h47] = 8'h12;

    // Reset with a valid aligned LW presented: strobes must stay low
    rst_n = 1'b0; req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
    req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = '0; req_rd = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_bad_addr", bad_addr, 32'd0);
    chk("rst_wmem", {28'd0, wmem}, 32'd0);
    chk("rst_rmem", {27'd0, rmem}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b1;

    // Directed loads from preloaded word
    do_req(1, 0, 3'd2, 32'h40, '0, 5'd3);
    chk("lw40_const", last_wb, 32'h80817F01);
    do_req(1, 0, 3'd0, 32'h42, '0, 5'd4);
    chk("lb42_const", last_wb, 32'hFFFFFF81);
    do_req(1, 0, 3'd4, 32'h42, '0, 5'd5);
    chk("lbu42_const", last_wb, 32'h00000081);
    do_req(1, 0, 3'd1, 32'h42, '0, 5'd6);
    chk("lh42_const", last_wb, 32'hFFFF8081);

    // Byte store then readback
    do_req(0, 1, 3'd0, 32'h43, 32'h000000AA, 5'd0);
    do_req(1, 0, 3'd2, 32'h40, '0, 5'd7);
    chk("lw40_after_sb", last_wb, 32'hAA817F01);

    // Misaligned halfword store leaves memory unchanged
    do_req(0, 1, 3'd1, 32'h41, 32'h0000BEEF, 5'd0);
    do_req(1, 0, 3'd2, 32'h40, '0, 5'd8);
    chk("lw40_after_sh_mis", last_wb, 32'hAA817F01);

    // Malformed and no-op requests
    do_req(1, 1, 3'd2, 32'h48, 32'h11111111, 5'd9);
    do_req(1, 0, 3'd3, 32'h48, '0, 5'd10);
    do_req(0, 1, 3'd4, 32'h48, 32'h22222222, 5'd0);
    do_req(0, 0, 3'd2, 32'h48, 32'h33333333, 5'd11);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h40; req_rd = 5'd12;
    @(posedge clk); #1;
    chk("b2b_ready_low", {31'd0, req_ready}, 32'd0);
    req_addr = 32'h44; req_rd = 5'd13;
    @(posedge clk); #1;
    chk("b2b_wb1_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb1_rd", {27'd0, wb_rd}, 32'd12);
    chk("b2b_wb1_data", wb_data, model_load(32'h40, 4, 0));
    chk("b2b_ready_on_wb", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_gap", {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_wb2_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb2_rd", {27'd0, wb_rd}, 32'd13);
    chk("b2b_wb2_data", wb_data, 32'h12345678);
    @(posedge clk); #1;
    chk("b2b_end", {31'd0, wb_valid}, 32'd0);

    // Reset during LOAD_WAIT abandons the load
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_rd = 5'd14;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_ready_low", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rw_no_wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rw_ready_release", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rw_no_wb_late", {31'd0, wb_valid}, 32'd0);

    // Randomized traffic against the byte-level model
    for (int k = 0; k < 80; k++) begin
      int unsigned kind;
      bit ld, st;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      ld = (kind == 1) || (kind >= 2 && kind <= 5);
      st = (kind == 1) || (kind >= 6);
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'd0 : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : a[1:0];
      do_req(ld, st, f3, a, $urandom, 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
